// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage owning the PC, one-outstanding imem fetch, output slot plus skid entry, redirect flush
//   clk, reset_n          : clock, async active-low reset
//   stall                 : IF/ID hold, slot is not consumed this edge
//   redirect, redirect_pc : taken branch/jump from ID, target forced word-aligned
//   imem_req/addr/ready   : request handshake, imem_rvalid/rdata : response
//   IF_Instr/PC/NPC/valid : instruction triple for IF/ID, NOP_INSTR bubble when not valid
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_Instr,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_NPC,
   output logic        IF_valid
);
   typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;
   state_t state, state_nx;
   logic [31:0] fetch_pc, req_pc, slot_instr, skid_instr, skid_pc;
   logic skid_valid, consume, resp, accept, to_skid;
   logic [1:0] occ;
   // The arriving word still needs storage, so only a consumed slot frees room;
   // this caps slot + skid + outstanding at two and the skid can never overflow.
   always_comb begin
      consume  = IF_valid && !stall;
      resp     = state == WAIT && imem_rvalid;
      occ      = 2'(IF_valid) + 2'(skid_valid) + 2'(state == WAIT) - 2'(consume);
      imem_req = reset_n && !redirect && (state == RUN || imem_rvalid) && occ < 2'd2;
      accept   = imem_req && imem_ready;
      to_skid  = resp && IF_valid && (!consume || skid_valid);
      state_nx = redirect ? ((state != RUN && !imem_rvalid) ? DROP : RUN)
               : accept ? WAIT : (imem_rvalid ? RUN : state);
   end
   assign imem_addr = fetch_pc;
   assign IF_Instr  = IF_valid ? slot_instr : NOP_INSTR;
   assign IF_NPC    = IF_PC + 32'd4;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         fetch_pc   <= RESET_PC;
         req_pc     <= RESET_PC;
         IF_valid   <= 1'b0;
         IF_PC      <= RESET_PC;
         slot_instr <= NOP_INSTR;
         skid_valid <= 1'b0;
         skid_instr <= NOP_INSTR;
         skid_pc    <= RESET_PC;
      end else begin
         state <= state_nx;
         if (redirect) begin
            fetch_pc   <= {redirect_pc[31:2], 2'b00};
            IF_valid   <= 1'b0;
            skid_valid <= 1'b0;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + 32'd4;
               req_pc   <= fetch_pc;
            end
            if (consume && skid_valid) begin
               slot_instr <= skid_instr;
               IF_PC      <= skid_pc;
               IF_valid   <= 1'b1;
            end else if (resp && (consume || !IF_valid)) begin
               slot_instr <= imem_rdata;
               IF_PC      <= req_pc;
               IF_valid   <= 1'b1;
            end else if (consume) begin
               IF_valid <= 1'b0;
            end
            if (to_skid) begin
               skid_instr <= imem_rdata;
               skid_pc    <= req_pc;
               skid_valid <= 1'b1;
            end else if (consume) begin
               skid_valid <= 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset_n && !redirect && to_skid && !consume) assert (!skid_valid);
   end
endmodule
